// File: rtl/lookup_scheduler_pkg.sv
// Shared types and helpers for the lookup scheduler: source-id tag type and
// the pointer-width helper used to size the ingress and tag FIFOs.
package lookup_scheduler_pkg;

    localparam int SRC_W = 1;

    // One tag entry: the source that owns an in-flight lookup.
    typedef logic [SRC_W-1:0] tag_t;

    // Number of address bits needed to index 'value' entries (value >= 2).
    function automatic int log2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (value > (32'sd1 <<< i)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/lookup_scheduler_fifo.sv
// sched_fifo: small synchronous FIFO with occupancy count, a pop of up to two
// entries per cycle, and combinational peek of the head and head+1 entries.
module sched_fifo
    import lookup_scheduler_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic [1:0]             pop_cnt,
    output logic [WIDTH-1:0]       head,
    output logic [WIDTH-1:0]       head_next,
    output logic [log2_f(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = log2_f(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;

    // A push into a full FIFO is dropped; the caller's ready gates it anyway.
    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push & ~full;
    assign head      = mem_r[rd_ptr_r];
    assign head_next = mem_r[rd_ptr_r + PTR_W'(1'b1)];
    assign count     = count_r;

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Read/write pointers and occupancy; the caller never pops more than count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_cnt);
            count_r  <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_cnt);
        end
    end

endmodule

// File: rtl/lookup_scheduler.sv
// lookup_scheduler: two-source ingress scheduler feeding the dual-port
// classification pipeline, with per-port source tags used to route results.
module lookup_scheduler
    import lookup_scheduler_pkg::*;
#(
    parameter int PACKET_WIDTH = 104,
    parameter int RULE_ID      = 14,
    parameter int FIFO_DEPTH   = 4,
    parameter int TAG_DEPTH    = 16
) (
    input  logic                    clk,
    input  logic                    RSTn,
    input  logic [PACKET_WIDTH-1:0] src0_packet,
    input  logic                    src0_valid,
    output logic                    src0_ready,
    input  logic [PACKET_WIDTH-1:0] src1_packet,
    input  logic                    src1_valid,
    output logic                    src1_ready,
    output logic [PACKET_WIDTH-1:0] packet_out1,
    output logic [PACKET_WIDTH-1:0] packet_out2,
    output logic                    data_valid_out1,
    output logic                    data_valid_out2,
    input  logic [RULE_ID-1:0]      rule_id_in1,
    input  logic [RULE_ID-1:0]      rule_id_in2,
    input  logic                    data_valid_in1,
    input  logic                    data_valid_in2,
    input  logic                    action_valid_in1,
    input  logic                    action_valid_in2,
    output logic                    res_valid_a,
    output logic                    res_valid_b,
    output logic                    res_src_a,
    output logic                    res_src_b,
    output logic [RULE_ID-1:0]      res_rule_id_a,
    output logic [RULE_ID-1:0]      res_rule_id_b,
    output logic                    res_hit_a,
    output logic                    res_hit_b,
    output logic                    err_orphan
);

    localparam int FCNT_W = log2_f(FIFO_DEPTH) + 1;
    localparam int TCNT_W = log2_f(TAG_DEPTH) + 1;

    // Ingress FIFO status
    logic [PACKET_WIDTH-1:0] in0_head_s, in0_next_s, in1_head_s, in1_next_s;
    logic [FCNT_W-1:0]       in0_count_s, in1_count_s;
    logic                    in0_full_s, in1_full_s, in0_empty_s, in1_empty_s;
    logic [1:0]              pop0_s, pop1_s;

    // Tag FIFO status
    tag_t                    tag1_head_s, tag2_head_s;
    tag_t                    tag1_next_unused_s, tag2_next_unused_s;
    logic [TCNT_W-1:0]       tag1_count_unused_s, tag2_count_unused_s;
    logic                    tag1_full_s, tag2_full_s, tag1_empty_s, tag2_empty_s;
    logic                    tag1_pop_s, tag2_pop_s;

    // Issue decision
    logic                    rr_r, rr_nxt_s, both_ne_s;
    logic                    first_has_s, second_has_s, first_go_s, second_go_s;
    logic [PACKET_WIDTH-1:0] first_pkt_s, second_pkt_s;
    tag_t                    first_src_s, second_src_s;
    logic                    iss1_v_s, iss2_v_s;
    logic [PACKET_WIDTH-1:0] iss1_pkt_s, iss2_pkt_s;
    tag_t                    iss1_src_s, iss2_src_s;

    // Registered pipeline-facing outputs
    logic [PACKET_WIDTH-1:0] packet_out1_r, packet_out2_r;
    logic                    data_valid_out1_r, data_valid_out2_r;

    // Result routing
    logic                    la_v_s, lb_v_s, orphan_s;
    tag_t                    la_src_s, lb_src_s;
    logic [RULE_ID-1:0]      la_rule_s, lb_rule_s;
    logic                    la_hit_s, lb_hit_s;
    logic                    res_valid_a_r, res_valid_b_r, res_src_a_r, res_src_b_r;
    logic [RULE_ID-1:0]      res_rule_id_a_r, res_rule_id_b_r;
    logic                    res_hit_a_r, res_hit_b_r, err_orphan_r;

    sched_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(FIFO_DEPTH)) u_in0 (
        .clk(clk), .rst_n(RSTn), .push(src0_valid), .push_data(src0_packet),
        .pop_cnt(pop0_s), .head(in0_head_s), .head_next(in0_next_s),
        .count(in0_count_s), .full(in0_full_s), .empty(in0_empty_s)
    );

    sched_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(FIFO_DEPTH)) u_in1 (
        .clk(clk), .rst_n(RSTn), .push(src1_valid), .push_data(src1_packet),
        .pop_cnt(pop1_s), .head(in1_head_s), .head_next(in1_next_s),
        .count(in1_count_s), .full(in1_full_s), .empty(in1_empty_s)
    );

    sched_fifo #(.WIDTH(SRC_W), .DEPTH(TAG_DEPTH)) u_tag1 (
        .clk(clk), .rst_n(RSTn), .push(iss1_v_s), .push_data(iss1_src_s),
        .pop_cnt({1'b0, tag1_pop_s}), .head(tag1_head_s), .head_next(tag1_next_unused_s),
        .count(tag1_count_unused_s), .full(tag1_full_s), .empty(tag1_empty_s)
    );

    sched_fifo #(.WIDTH(SRC_W), .DEPTH(TAG_DEPTH)) u_tag2 (
        .clk(clk), .rst_n(RSTn), .push(iss2_v_s), .push_data(iss2_src_s),
        .pop_cnt({1'b0, tag2_pop_s}), .head(tag2_head_s), .head_next(tag2_next_unused_s),
        .count(tag2_count_unused_s), .full(tag2_full_s), .empty(tag2_empty_s)
    );

    // Ready is purely count-based: a full FIFO never accepts, even while popping.
    assign src0_ready = ~in0_full_s;
    assign src1_ready = ~in1_full_s;

    // Pick up to two candidates: the rr source first when both have data,
    // otherwise the single source's head then its second entry.
    always_comb begin
        both_ne_s    = 1'b0;
        first_has_s  = 1'b0;
        second_has_s = 1'b0;
        first_pkt_s  = {PACKET_WIDTH{1'b0}};
        second_pkt_s = {PACKET_WIDTH{1'b0}};
        first_src_s  = 1'b0;
        second_src_s = 1'b0;
        case ({~in1_empty_s, ~in0_empty_s})
            2'b11: begin
                both_ne_s    = 1'b1;
                first_has_s  = 1'b1;
                second_has_s = 1'b1;
                if (rr_r) begin
                    first_pkt_s  = in1_head_s;
                    first_src_s  = 1'b1;
                    second_pkt_s = in0_head_s;
                    second_src_s = 1'b0;
                end else begin
                    first_pkt_s  = in0_head_s;
                    first_src_s  = 1'b0;
                    second_pkt_s = in1_head_s;
                    second_src_s = 1'b1;
                end
            end
            2'b01: begin
                first_has_s  = 1'b1;
                first_pkt_s  = in0_head_s;
                first_src_s  = 1'b0;
                second_has_s = (in0_count_s >= FCNT_W'(2));
                second_pkt_s = in0_next_s;
                second_src_s = 1'b0;
            end
            2'b10: begin
                first_has_s  = 1'b1;
                first_pkt_s  = in1_head_s;
                first_src_s  = 1'b1;
                second_has_s = (in1_count_s >= FCNT_W'(2));
                second_pkt_s = in1_next_s;
                second_src_s = 1'b1;
            end
            default: begin
                first_has_s  = 1'b0;
                second_has_s = 1'b0;
            end
        endcase
    end

    // Map candidates onto eligible ports (port2 stands in for a blocked port1)
    // and derive the per-source dequeue counts and next rr pointer.
    always_comb begin
        iss1_v_s    = 1'b0;
        iss2_v_s    = 1'b0;
        iss1_pkt_s  = {PACKET_WIDTH{1'b0}};
        iss2_pkt_s  = {PACKET_WIDTH{1'b0}};
        iss1_src_s  = 1'b0;
        iss2_src_s  = 1'b0;
        first_go_s  = 1'b0;
        second_go_s = 1'b0;
        if (!tag1_full_s) begin
            iss1_v_s   = first_has_s;
            iss1_pkt_s = first_pkt_s;
            iss1_src_s = first_src_s;
            first_go_s = first_has_s;
            if (!tag2_full_s) begin
                iss2_v_s    = second_has_s;
                iss2_pkt_s  = second_pkt_s;
                iss2_src_s  = second_src_s;
                second_go_s = second_has_s;
            end else begin
                second_go_s = 1'b0;
            end
        end else if (!tag2_full_s) begin
            iss2_v_s   = first_has_s;
            iss2_pkt_s = first_pkt_s;
            iss2_src_s = first_src_s;
            first_go_s = first_has_s;
        end else begin
            first_go_s = 1'b0;
        end
        pop0_s = {1'b0, first_go_s & ~first_src_s[0]} + {1'b0, second_go_s & ~second_src_s[0]};
        pop1_s = {1'b0, first_go_s &  first_src_s[0]} + {1'b0, second_go_s &  second_src_s[0]};
        if (both_ne_s && first_go_s) begin
            rr_nxt_s = ~rr_r;
        end else begin
            rr_nxt_s = rr_r;
        end
    end

    // Pipeline-facing registers: valid per issue cycle, header held when idle.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            rr_r              <= 1'b0;
            data_valid_out1_r <= 1'b0;
            data_valid_out2_r <= 1'b0;
            packet_out1_r     <= {PACKET_WIDTH{1'b0}};
            packet_out2_r     <= {PACKET_WIDTH{1'b0}};
        end else begin
            rr_r              <= rr_nxt_s;
            data_valid_out1_r <= iss1_v_s;
            data_valid_out2_r <= iss2_v_s;
            if (iss1_v_s) begin
                packet_out1_r <= iss1_pkt_s;
            end
            if (iss2_v_s) begin
                packet_out2_r <= iss2_pkt_s;
            end
        end
    end

    // Returning results: port1 takes lane a when present, else port2 does;
    // lane b is used only when both ports return together.
    always_comb begin
        tag1_pop_s = data_valid_in1 & ~tag1_empty_s;
        tag2_pop_s = data_valid_in2 & ~tag2_empty_s;
        orphan_s   = (data_valid_in1 & tag1_empty_s) | (data_valid_in2 & tag2_empty_s);
        lb_v_s     = data_valid_in1 & data_valid_in2 & ~tag2_empty_s;
        lb_src_s   = tag2_head_s;
        lb_rule_s  = rule_id_in2;
        lb_hit_s   = action_valid_in2;
        if (data_valid_in1) begin
            la_v_s    = ~tag1_empty_s;
            la_src_s  = tag1_head_s;
            la_rule_s = rule_id_in1;
            la_hit_s  = action_valid_in1;
        end else begin
            la_v_s    = data_valid_in2 & ~tag2_empty_s;
            la_src_s  = tag2_head_s;
            la_rule_s = rule_id_in2;
            la_hit_s  = action_valid_in2;
        end
    end

    // Result lane registers and the sticky orphan flag.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            res_valid_a_r   <= 1'b0;
            res_valid_b_r   <= 1'b0;
            res_src_a_r     <= 1'b0;
            res_src_b_r     <= 1'b0;
            res_rule_id_a_r <= {RULE_ID{1'b0}};
            res_rule_id_b_r <= {RULE_ID{1'b0}};
            res_hit_a_r     <= 1'b0;
            res_hit_b_r     <= 1'b0;
            err_orphan_r    <= 1'b0;
        end else begin
            res_valid_a_r <= la_v_s;
            res_valid_b_r <= lb_v_s;
            err_orphan_r  <= err_orphan_r | orphan_s;
            if (la_v_s) begin
                res_src_a_r     <= la_src_s[0];
                res_rule_id_a_r <= la_rule_s;
                res_hit_a_r     <= la_hit_s;
            end
            if (lb_v_s) begin
                res_src_b_r     <= lb_src_s[0];
                res_rule_id_b_r <= lb_rule_s;
                res_hit_b_r     <= lb_hit_s;
            end
        end
    end

    assign packet_out1     = packet_out1_r;
    assign packet_out2     = packet_out2_r;
    assign data_valid_out1 = data_valid_out1_r;
    assign data_valid_out2 = data_valid_out2_r;
    assign res_valid_a     = res_valid_a_r;
    assign res_valid_b     = res_valid_b_r;
    assign res_src_a       = res_src_a_r;
    assign res_src_b       = res_src_b_r;
    assign res_rule_id_a   = res_rule_id_a_r;
    assign res_rule_id_b   = res_rule_id_b_r;
    assign res_hit_a       = res_hit_a_r;
    assign res_hit_b       = res_hit_b_r;
    assign err_orphan      = err_orphan_r;

endmodule

// File: tb/tb_lookup_scheduler.sv
// Directed self-checking bench for lookup_scheduler.
module tb_lookup_scheduler;

    localparam int PW = 104;
    localparam int RW = 14;

    logic          clk = 1'b0;
    logic          RSTn;
    logic [PW-1:0] src0_packet, src1_packet, packet_out1, packet_out2;
    logic          src0_valid, src0_ready, src1_valid, src1_ready;
    logic          data_valid_out1, data_valid_out2;
    logic [RW-1:0] rule_id_in1, rule_id_in2, res_rule_id_a, res_rule_id_b;
    logic          data_valid_in1, data_valid_in2, action_valid_in1, action_valid_in2;
    logic          res_valid_a, res_valid_b, res_src_a, res_src_b, res_hit_a, res_hit_b;
    logic          err_orphan;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lookup_scheduler dut (
        .clk(clk), .RSTn(RSTn),
        .src0_packet(src0_packet), .src0_valid(src0_valid), .src0_ready(src0_ready),
        .src1_packet(src1_packet), .src1_valid(src1_valid), .src1_ready(src1_ready),
        .packet_out1(packet_out1), .packet_out2(packet_out2),
        .data_valid_out1(data_valid_out1), .data_valid_out2(data_valid_out2),
        .rule_id_in1(rule_id_in1), .rule_id_in2(rule_id_in2),
        .data_valid_in1(data_valid_in1), .data_valid_in2(data_valid_in2),
        .action_valid_in1(action_valid_in1), .action_valid_in2(action_valid_in2),
        .res_valid_a(res_valid_a), .res_valid_b(res_valid_b),
        .res_src_a(res_src_a), .res_src_b(res_src_b),
        .res_rule_id_a(res_rule_id_a), .res_rule_id_b(res_rule_id_b),
        .res_hit_a(res_hit_a), .res_hit_b(res_hit_b),
        .err_orphan(err_orphan)
    );

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src0_valid = 1'b0; src1_valid = 1'b0;
        src0_packet = '0; src1_packet = '0;
        data_valid_in1 = 1'b0; data_valid_in2 = 1'b0;
        action_valid_in1 = 1'b0; action_valid_in2 = 1'b0;
        rule_id_in1 = '0; rule_id_in2 = '0;
    endtask

    task automatic apply_reset();
        RSTn = 1'b0;
        idle();
        step();
        step();
        RSTn = 1'b1;
    endtask

    initial begin
        int j;
        logic [PW-1:0] ea, eb;

        // ---------------- reset state
        RSTn = 1'b0;
        idle();
        step();
        step();
        check_val("rst_dv1", data_valid_out1, 0);
        check_val("rst_dv2", data_valid_out2, 0);
        check_val("rst_pkt1", packet_out1, 0);
        check_val("rst_resva", res_valid_a, 0);
        check_val("rst_orphan", err_orphan, 0);
        check_val("rst_ready", {src0_ready, src1_ready}, 2'b11);
        RSTn = 1'b1;

        // ---------------- latency: accept at E0, valid after E1, then hold
        src0_valid = 1'b1; src0_packet = 104'hABC;
        step();
        src0_valid = 1'b0;
        check_val("lat_e0_dv1", data_valid_out1, 0);
        step();
        check_val("lat_e1_dv", {data_valid_out1, data_valid_out2}, 2'b10);
        check_val("lat_e1_pkt1", packet_out1, 104'hABC);
        step();
        check_val("lat_idle_dv1", data_valid_out1, 0);
        check_val("lat_hold_pkt1", packet_out1, 104'hABC);

        // ---------------- fairness: both sources every cycle
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            if (k < 8) begin
                src0_valid = 1'b1; src0_packet = 104'hA0 + PW'(k);
                src1_valid = 1'b1; src1_packet = 104'hB0 + PW'(k);
            end else begin
                src0_valid = 1'b0; src1_valid = 1'b0;
            end
            step();
            if (k >= 1) begin
                j = k - 1;
                ea = 104'hA0 + PW'(j);
                eb = 104'hB0 + PW'(j);
                check_val("fair_dv", {data_valid_out1, data_valid_out2}, 2'b11);
                check_val("fair_pkt1", packet_out1, (j % 2 == 0) ? ea : eb);
                check_val("fair_pkt2", packet_out2, (j % 2 == 0) ? eb : ea);
            end
        end

        // ---------------- single-source burst: order kept on port1
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                src0_valid = 1'b1; src0_packet = 104'hC0 + PW'(k);
            end else begin
                src0_valid = 1'b0;
            end
            step();
            if (k >= 1) begin
                check_val("burst_dv", {data_valid_out1, data_valid_out2}, 2'b10);
                check_val("burst_pkt1", packet_out1, 104'hC0 + PW'(k - 1));
            end
        end

        // ---------------- backpressure: no results return, src1 only
        apply_reset();
        for (int k = 0; k < 36; k++) begin
            src1_valid = 1'b1; src1_packet = 104'h100 + PW'(k);
            step();
            if (k == 16) begin
                check_val("bp_p1_last_dv", {data_valid_out1, data_valid_out2}, 2'b10);
                check_val("bp_p1_last_pkt", packet_out1, 104'h10F);
            end
            if (k == 17) begin
                check_val("bp_p2_sub_dv", {data_valid_out1, data_valid_out2}, 2'b01);
                check_val("bp_p2_sub_pkt", packet_out2, 104'h110);
            end
            if (k == 32) begin
                check_val("bp_p2_last_dv", data_valid_out2, 1);
                check_val("bp_p2_last_pkt", packet_out2, 104'h11F);
            end
            if (k == 33) begin
                check_val("bp_stall_dv", {data_valid_out1, data_valid_out2}, 2'b00);
            end
            if (k == 34) begin
                check_val("bp_ready_cnt3", src1_ready, 1);
            end
            if (k == 35) begin
                check_val("bp_ready_cnt4", src1_ready, 0);
            end
        end
        src1_valid = 1'b0;
        step();
        check_val("bp_stall_hold", {data_valid_out1, data_valid_out2, src1_ready}, 3'b000);

        // release one result on port1 -> exactly one more issue
        data_valid_in1 = 1'b1; rule_id_in1 = 14'h0011; action_valid_in1 = 1'b1;
        step();
        check_val("rel1_lane_a", {res_valid_a, res_src_a, res_hit_a, res_valid_b}, 4'b1110);
        check_val("rel1_rule_a", res_rule_id_a, 14'h0011);
        data_valid_in1 = 1'b0; action_valid_in1 = 1'b0;
        src1_valid = 1'b1; src1_packet = 104'hDEAD;
        check_val("full_ready_low", src1_ready, 0);
        step();
        src1_valid = 1'b0;
        check_val("rel1_issue_dv", {data_valid_out1, data_valid_out2}, 2'b10);
        check_val("rel1_issue_pkt", packet_out1, 104'h120);
        check_val("full_ready_back", src1_ready, 1);
        step();
        check_val("rel1_one_slot", {data_valid_out1, data_valid_out2}, 2'b00);

        // release both ports -> pair, older on port1
        data_valid_in1 = 1'b1; data_valid_in2 = 1'b1;
        rule_id_in1 = 14'h0021; rule_id_in2 = 14'h0022;
        step();
        check_val("rel2_lanes", {res_valid_a, res_valid_b, res_src_a, res_src_b}, 4'b1111);
        check_val("rel2_rule_b", res_rule_id_b, 14'h0022);
        data_valid_in1 = 1'b0; data_valid_in2 = 1'b0;
        step();
        check_val("rel2_dv", {data_valid_out1, data_valid_out2}, 2'b11);
        check_val("rel2_pkt1", packet_out1, 104'h121);
        check_val("rel2_pkt2", packet_out2, 104'h122);

        // port2-only result maps to lane a; port2 then substitutes for port1
        data_valid_in2 = 1'b1; rule_id_in2 = 14'h0033; action_valid_in2 = 1'b0;
        step();
        check_val("p2only_lane", {res_valid_a, res_src_a, res_hit_a, res_valid_b}, 4'b1100);
        check_val("p2only_rule", res_rule_id_a, 14'h0033);
        data_valid_in2 = 1'b0;
        step();
        check_val("p2sub_dv", {data_valid_out1, data_valid_out2}, 2'b01);
        check_val("p2sub_pkt", packet_out2, 104'h123);

        // free port1 again: nothing left, the rejected header must not appear
        data_valid_in1 = 1'b1;
        step();
        data_valid_in1 = 1'b0;
        step();
        check_val("no_dup_dv", {data_valid_out1, data_valid_out2}, 2'b00);
        check_val("no_orphan_yet", err_orphan, 0);

        // ---------------- reset mid-operation, then a stale result
        src0_valid = 1'b1; src0_packet = 104'hEE0;
        src1_valid = 1'b1; src1_packet = 104'hEE1;
        step();
        RSTn = 1'b0;
        idle();
        step();
        check_val("mid_rst_outs", {data_valid_out1, data_valid_out2, res_valid_a, res_valid_b}, 4'b0000);
        check_val("mid_rst_ready", {src0_ready, src1_ready, err_orphan}, 3'b110);
        RSTn = 1'b1;
        data_valid_in1 = 1'b1; rule_id_in1 = 14'h0077;
        step();
        data_valid_in1 = 1'b0;
        check_val("stale_orphan", {res_valid_a, res_valid_b, err_orphan}, 3'b001);
        step();
        check_val("orphan_sticky", err_orphan, 1);
        check_val("stale_no_issue", {data_valid_out1, data_valid_out2}, 2'b00);

        // ---------------- routing through a 12-cycle loopback
        apply_reset();
        src0_valid = 1'b1; src0_packet = 104'h5A0;
        src1_valid = 1'b1; src1_packet = 104'h5B0;
        step();
        src0_packet = 104'h5A1; src1_packet = 104'h5B1;
        step();
        src0_valid = 1'b0; src1_valid = 1'b0;
        check_val("route_iss1", {packet_out1, packet_out2}, {104'h5A0, 104'h5B0});
        step();
        check_val("route_iss2", {packet_out1, packet_out2}, {104'h5B1, 104'h5A1});
        repeat (11) step();
        data_valid_in1 = 1'b1; rule_id_in1 = 14'h005; action_valid_in1 = 1'b1;
        data_valid_in2 = 1'b1; rule_id_in2 = 14'h3A1; action_valid_in2 = 1'b0;
        step();
        check_val("route_a", {res_valid_a, res_src_a, res_hit_a}, 3'b101);
        check_val("route_a_rule", res_rule_id_a, 14'h005);
        check_val("route_b", {res_valid_b, res_src_b, res_hit_b}, 3'b110);
        check_val("route_b_rule", res_rule_id_b, 14'h3A1);
        data_valid_in1 = 1'b0; action_valid_in1 = 1'b0;
        rule_id_in2 = 14'h0B2; action_valid_in2 = 1'b1;
        step();
        check_val("route_p2_a", {res_valid_a, res_src_a, res_hit_a, res_valid_b}, 4'b1010);
        check_val("route_p2_rule", res_rule_id_a, 14'h0B2);
        data_valid_in2 = 1'b0; action_valid_in2 = 1'b0;
        data_valid_in1 = 1'b1; rule_id_in1 = 14'h0C3;
        step();
        check_val("route_p1_a", {res_valid_a, res_src_a, res_valid_b}, 3'b110);
        check_val("route_p1_rule", res_rule_id_a, 14'h0C3);
        data_valid_in1 = 1'b0;
        step();
        check_val("route_idle", {res_valid_a, res_valid_b, err_orphan}, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
